// File: rtl/cla_pkg.sv
// Shared definitions for the carry-lookahead propagate/generate front end:
// widths, skid-buffer state encoding and the p/g beat layout.
package cla_pkg;

    localparam int CLA_WIDTH = 16;
    localparam int CLA_GROUP = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_e;

    typedef struct packed {
        logic [CLA_WIDTH-1:0] p;
        logic [CLA_WIDTH-1:0] g;
        logic                 cin0;
    } pg_beat_t;

endpackage

// File: rtl/pg_skid_buf.sv
// Two-entry (main + skid) pipeline buffer with registered in_ready/out_valid.
// Output data always comes from main; skid only absorbs the beat in flight when downstream stalls.
module pg_skid_buf
    import cla_pkg::*;
#(
    parameter int DW = 2 * CLA_WIDTH + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o,
    output buf_state_e    state_o
);

    // Handshake: a beat transfers on a rising edge where valid && ready; ready
    // never depends combinationally on valid or on the opposite side's ready.
    buf_state_e    state_q;
    logic [DW-1:0] main_q;
    logic [DW-1:0] skid_q;
    logic          in_ready_q;
    logic          out_valid_q;

    logic accept;
    logic consume;

    assign accept  = in_valid_i && in_ready_q;
    assign consume = out_valid_q && out_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_q      <= in_data_i;
                        state_q     <= ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ONE: begin
                    if (accept && !consume) begin
                        skid_q     <= in_data_i;
                        state_q    <= FULL;
                        in_ready_q <= 1'b0;
                    end else if (!accept && consume) begin
                        state_q     <= EMPTY;
                        out_valid_q <= 1'b0;
                    end else if (accept && consume) begin
                        main_q <= in_data_i;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a drain is possible
                    if (consume) begin
                        main_q     <= skid_q;
                        state_q    <= ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = main_q;
    assign state_o     = state_q;

endmodule

// File: rtl/cla_pg_stage.sv
// First stage of a carry-lookahead adder/subtractor: forms per-bit propagate and
// generate plus the group-0 carry-in, then registers them through a skid buffer.
module cla_pg_stage
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH  // multiple of CLA_GROUP for the downstream 4-bit groups
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] g,
    output logic             cin0,
    output buf_state_e       dbg_state_o
);

    localparam int DW = 2 * WIDTH + 1;

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic [DW-1:0]    beat_in;
    logic [DW-1:0]    beat_out;

    // Subtraction is A + ~B + 1, so the inversion and forced carry happen before p/g.
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? 1'b1 : cin;
    assign beat_in = {a ^ b_eff, a & b_eff, cin_eff};

    pg_skid_buf #(
        .DW(DW)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (beat_in),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (beat_out),
        .state_o    (dbg_state_o)
    );

    assign p    = beat_out[DW-1 -: WIDTH];
    assign g    = beat_out[WIDTH -: WIDTH];
    assign cin0 = beat_out[0];

endmodule

// File: tb/tb_cla_pg_stage.sv
// Directed bench for cla_pg_stage: add/subtract vectors, backpressure, streaming and reset in FULL.
module tb_cla_pg_stage;
    import cla_pkg::*;

    localparam int W = CLA_WIDTH;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] p;
    logic [W-1:0] g;
    logic         cin0;
    buf_state_e   dbg_state;

    int total = 0;
    int bad   = 0;

    pg_beat_t exp_q[$];

    cla_pg_stage #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .cin        (cin),
        .sub        (sub),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .p          (p),
        .g          (g),
        .cin0       (cin0),
        .dbg_state_o(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic cv, input logic sv);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        cin      = cv;
        sub      = sv;
    endtask

    task automatic check_out(input string tag, input logic [W-1:0] ep,
                             input logic [W-1:0] eg, input logic ec);
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".p"}, 64'(p), 64'(ep));
        check({tag, ".g"}, 64'(g), 64'(eg));
        check({tag, ".cin0"}, 64'(cin0), 64'(ec));
    endtask

    task automatic check_state(input string tag, input buf_state_e es, input logic erdy);
        check({tag, ".state"}, 64'(dbg_state), 64'(es));
        check({tag, ".in_ready"}, 64'(in_ready), 64'(erdy));
    endtask

    function automatic pg_beat_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                       input logic cv, input logic sv);
        pg_beat_t r;
        logic [W-1:0] bx;
        bx     = sv ? ~bv : bv;
        r.p    = av ^ bx;
        r.g    = av & bx;
        r.cin0 = sv | cv;
        return r;
    endfunction

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;

        // Reset state
        #12;
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.p", 64'(p), 64'd0);
        check("rst.g", 64'(g), 64'd0);
        check("rst.cin0", 64'(cin0), 64'd0);
        check_state("rst", EMPTY, 1'b1);
        step();
        rst_n = 1'b1;

        // Add, subtract, add-with-carry back to back with out_ready=1
        drive(16'h00FF, 16'h0001, 1'b0, 1'b0);
        step();
        check_out("add", 16'h00FE, 16'h0001, 1'b0);
        check_state("add", ONE, 1'b1);
        drive(16'h0005, 16'h0003, 1'b0, 1'b1);
        step();
        check_out("sub", 16'hFFF9, 16'h0004, 1'b1);
        check_state("sub_acc_cons", ONE, 1'b1);
        drive(16'h1234, 16'h0F0F, 1'b1, 1'b0);
        step();
        check_out("addc", 16'h1D3B, 16'h0204, 1'b1);
        check_state("addc_acc_cons", ONE, 1'b1);
        in_valid = 1'b0;
        step();
        check("drain.out_valid", 64'(out_valid), 64'd0);
        check_state("drain", EMPTY, 1'b1);

        // Backpressure: A0, A1 accepted, A2 waits, A0 held
        out_ready = 1'b0;
        drive(16'h1111, 16'h2222, 1'b0, 1'b0);
        step();
        check_out("bp.a0", 16'h3333, 16'h0000, 1'b0);
        check_state("bp.a0", ONE, 1'b1);
        drive(16'hFFFF, 16'h0001, 1'b1, 1'b0);
        step();
        check_out("bp.a0_hold1", 16'h3333, 16'h0000, 1'b0);
        check_state("bp.a1", FULL, 1'b0);
        drive(16'h00F0, 16'h0F00, 1'b0, 1'b1);
        step();
        check_out("bp.a0_hold2", 16'h3333, 16'h0000, 1'b0);
        check_state("bp.a2_wait1", FULL, 1'b0);
        step();
        check_out("bp.a0_hold3", 16'h3333, 16'h0000, 1'b0);
        check_state("bp.a2_wait2", FULL, 1'b0);
        out_ready = 1'b1;
        step();
        check_out("bp.a1_out", 16'hFFFE, 16'h0001, 1'b1);
        check_state("bp.drain1", ONE, 1'b1);
        step();
        check_out("bp.a2_out", 16'hF00F, 16'h00F0, 1'b1);
        check_state("bp.drain2", ONE, 1'b1);
        in_valid = 1'b0;
        step();
        check("bp.empty", 64'(out_valid), 64'd0);

        // Streaming: 32 random beats, one per cycle
        for (int i = 0; i < 32; i++) begin
            drive(W'($urandom_range(0, 16'hFFFF)), W'($urandom_range(0, 16'hFFFF)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            exp_q.push_back(model(a, b, cin, sub));
            step();
            begin
                pg_beat_t e;
                e = exp_q.pop_front();
                check_out($sformatf("stream%0d", i), e.p, e.g, e.cin0);
                check($sformatf("stream%0d.in_ready", i), 64'(in_ready), 64'd1);
            end
        end
        in_valid = 1'b0;
        step();
        check("stream.empty", 64'(out_valid), 64'd0);

        // Reset while FULL
        out_ready = 1'b0;
        drive(16'hAAAA, 16'h5555, 1'b0, 1'b0);
        step();
        drive(16'h0F0F, 16'h0F0F, 1'b1, 1'b0);
        step();
        check_state("full_pre_rst", FULL, 1'b0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("rstfull.out_valid", 64'(out_valid), 64'd0);
        check("rstfull.p", 64'(p), 64'd0);
        check("rstfull.g", 64'(g), 64'd0);
        check_state("rstfull", EMPTY, 1'b1);
        out_ready = 1'b1;
        step();
        check("rstfull.held", 64'(out_valid), 64'd0);
        rst_n = 1'b1;
        drive(16'h8001, 16'h8001, 1'b0, 1'b0);
        step();
        check_out("post_rst_first", 16'h0000, 16'h8001, 1'b0);
        in_valid = 1'b0;
        step();
        check("post_rst.no_stale", 64'(out_valid), 64'd0);
        step();
        check("post_rst.no_stale2", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cla_pg_stage.md
CLA_PG_STAGE -- requirements
Module: cla_pg_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand width; it must be a multiple of 4.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: an operand beat is present.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the stage accepts a beat this cycle.
REQ-006 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-007 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-008 The block SHALL have port cin, input, 1 bit: carry-in, used only when sub=0.
REQ-009 The block SHALL have port sub, input, 1 bit: 1 selects A-B, 0 selects A+B+cin.
REQ-010 The block SHALL have port out_valid, output, 1 bit: a p/g beat is present.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the downstream 4-bit lookahead groups consume the beat.
REQ-012 The block SHALL have port p, output, WIDTH bits: per-bit propagate.
REQ-013 The block SHALL have port g, output, WIDTH bits: per-bit generate.
REQ-014 The block SHALL have port cin0, output, 1 bit: effective carry-in for lookahead group 0.

Function
REQ-015 The block SHALL form b_eff = sub ? ~b : b and cin_eff = sub ? 1 : cin.
REQ-016 The block SHALL compute p = a XOR b_eff and g = a AND b_eff per bit, and register them with cin0 = cin_eff; no carries are computed here.
REQ-017 An input beat SHALL be accepted iff in_valid && in_ready, and an output beat SHALL be consumed iff out_valid && out_ready.
REQ-018 Latency SHALL be 1 cycle: a beat accepted at edge N drives out_valid=1 with its p/g/cin0 after edge N when the main register was empty or was being consumed at edge N.
REQ-019 Storage SHALL be a 2-entry buffer (main + skid), and throughput SHALL be 1 beat/cycle while out_ready=1.
REQ-020 The buffer SHALL use states EMPTY (main empty), ONE (main full), FULL (main and skid full).
REQ-021 From EMPTY, an accept SHALL transition to ONE.
REQ-022 From ONE, an accept with no consume SHALL transition to FULL, with the new beat written to skid.
REQ-023 From ONE, a consume with no accept SHALL transition to EMPTY.
REQ-024 From ONE, a simultaneous accept and consume SHALL stay in ONE, with the new beat loaded to main.
REQ-025 From FULL, a consume SHALL move skid to main and transition to ONE; no accept is possible in FULL.
REQ-026 in_ready SHALL be registered, 0 exactly in FULL, and driven independently of in_valid and out_ready in the same cycle.
REQ-027 out_valid SHALL be 1 in ONE and FULL; p/g/cin0 SHALL always come from main and SHALL be held stable while out_valid && !out_ready.
REQ-028 Beats SHALL leave in acceptance order, with no drop and no duplication.
REQ-029 Inputs presented while in_ready=0 SHALL be ignored.
REQ-030 sub and cin SHALL be sampled with the same beat as a and b.

Reset
REQ-031 While rst_n=0, the block SHALL force out_valid=0, in_ready=1, p=0, g=0, cin0=0, skid contents 0, state EMPTY, asynchronously.
REQ-032 Reset asserted mid-stream SHALL discard all buffered beats, and the first beat SHALL be accepted on the first edge after rst_n deasserts.

Structure
REQ-033 Package cla_pkg SHALL hold the WIDTH default (16), the group size constant (4), the buffer state enum (EMPTY/ONE/FULL), and a pg_beat struct {p, g, cin0}.
REQ-034 The block SHALL instantiate exactly one sub-module, pg_skid_buf, which holds the 2-entry pg_beat buffer and handshake; p/g formation stays in cla_pg_stage.
REQ-035 The RTL SHALL have no combinational path from out_ready to in_ready.

Verification
REQ-036 Add: a=0x00FF, b=0x0001, cin=0, sub=0, out_ready=1 -> next cycle p=0x00FE, g=0x0001, cin0=0, out_valid=1.
REQ-037 Subtract: a=0x0005, b=0x0003, sub=1, cin=0 -> p=0xFFF9, g=0x0004, cin0=1.
REQ-038 Backpressure: out_ready=0, in_valid held for beats A0,A1,A2 -> A0 and A1 accepted; in_ready=0 after the edge accepting A1; A2 waits; A0 output held stable. Then out_ready=1 -> A0, A1, A2 exit on consecutive cycles in order.
REQ-039 Streaming: 32 random beats with out_ready=1 and in_valid=1 -> one output per cycle, each matching the reference model delayed by 1.
REQ-040 Simultaneous accept and consume in ONE -> state stays ONE and in_ready stays 1.
REQ-041 Reset in FULL: rst_n pulsed low -> out_valid=0 and in_ready=1 immediately; no stale beat is emitted afterwards.
